// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master round-robin Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GNT0  = 2'd1,
    GNT1  = 2'd2,
    ABORT = 2'd3
  } arb_state_e;

  localparam int DEFAULT_TIMEOUT = 255;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

endpackage

// File: rtl/wb_watchdog.sv
// Stall counter for the granted access; flags an abort when the slave never answers.
module wb_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  input  logic ack_i,
  output logic expire_o
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)
      count_d = '0;
    else if (en_i)
      count_d = count_q + CNT_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // A response arriving on the threshold cycle still wins over the abort.
  assign expire_o = (count_q == CNT_W'(TIMEOUT - 1)) & en_i & ~ack_i;

endmodule

// File: rtl/wb_rr_arbiter2.sv
// Two-master round-robin Wishbone arbiter with cyc-atomic grants and a watchdog abort.
module wb_rr_arbiter2
  import wb_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT,
  parameter int CNT_W   = 8
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic [31:0] m0_dat_o,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic [31:0] m1_dat_o,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,
  input  logic        s_err_i,
  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  arb_state_e  state_q;
  logic        last_q;
  logic [1:0]  grant_q;
  logic        timeout_q;
  logic        ownerCyc;
  logic        ownerStb;
  logic        wdExpire;

  assign ownerCyc = (state_q == GNT0) ? m0_cyc_i :
                    (state_q == GNT1) ? m1_cyc_i : 1'b0;
  assign ownerStb = (state_q == GNT0) ? m0_stb_i :
                    (state_q == GNT1) ? m1_stb_i : 1'b0;

  wb_watchdog #(
    .TIMEOUT (TIMEOUT),
    .CNT_W   (CNT_W)
  ) u_watchdog (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clr_i    (~ownerStb | s_ack_i | s_err_i | wdExpire),
    .en_i     (ownerStb),
    .ack_i    (s_ack_i | s_err_i),
    .expire_o (wdExpire)
  );

  // last_q doubles as the owner index while granted or aborting.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      grant_q   <= GRANT_NONE;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (m0_cyc_i && (!m1_cyc_i || last_q)) begin
            state_q <= GNT0;
            last_q  <= 1'b0;
            grant_q <= GRANT_M0;
          end else if (m1_cyc_i) begin
            state_q <= GNT1;
            last_q  <= 1'b1;
            grant_q <= GRANT_M1;
          end
        end
        GNT0, GNT1: begin
          if (wdExpire) begin
            state_q   <= ABORT;
            timeout_q <= 1'b1;
          end else if (!ownerCyc) begin
            state_q <= IDLE;
            grant_q <= GRANT_NONE;
          end
        end
        ABORT: begin
          state_q <= IDLE;
          grant_q <= GRANT_NONE;
        end
        default: begin
          state_q <= IDLE;
          grant_q <= GRANT_NONE;
        end
      endcase
    end
  end

  assign grant_o   = grant_q;
  assign timeout_o = timeout_q;
  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    case (state_q)
      GNT0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i;
        m0_ack_o = s_ack_i & m0_stb_i;
        m0_err_o = s_err_i & m0_stb_i;
      end
      GNT1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i;
        m1_ack_o = s_ack_i & m1_stb_i;
        m1_err_o = s_err_i & m1_stb_i;
      end
      ABORT: begin
        if (last_q)
          m1_err_o = 1'b1;
        else
          m0_err_o = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Self-checking bench for wb_rr_arbiter2: directed scenarios plus randomized traffic vs a reference model.
module tb_wb_rr_arbiter2;

  localparam int TO = 8;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i, s_dat_i;
  logic [3:0]  m0_sel_i, m1_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m1_we_i, m1_cyc_i, m1_stb_i;
  logic        s_ack_i, s_err_i;
  logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
  logic        s_we_o, s_cyc_o, s_stb_o, timeout_o;
  logic [1:0]  grant_o;

  int nCompared   = 0;
  int nMismatched = 0;

  typedef struct packed {
    logic [1:0]  grant;
    logic        scyc, sstb, swe;
    logic [31:0] sadr, sdat;
    logic [3:0]  ssel;
    logic        m0ack, m1ack, m0err, m1err, tmo;
    logic [31:0] m0dat, m1dat;
  } obs_t;

  obs_t actual;

  wb_rr_arbiter2 #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_sel_i(m0_sel_i), .m0_we_i(m0_we_i),
    .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
    .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_sel_i(m1_sel_i), .m1_we_i(m1_we_i),
    .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
    .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .s_err_i(s_err_i), .grant_o(grant_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  always_comb begin
    actual.grant = grant_o;
    actual.scyc  = s_cyc_o;
    actual.sstb  = s_stb_o;
    actual.swe   = s_we_o;
    actual.sadr  = s_adr_o;
    actual.sdat  = s_dat_o;
    actual.ssel  = s_sel_o;
    actual.m0ack = m0_ack_o;
    actual.m1ack = m1_ack_o;
    actual.m0err = m0_err_o;
    actual.m1err = m1_err_o;
    actual.tmo   = timeout_o;
    actual.m0dat = m0_dat_o;
    actual.m1dat = m1_dat_o;
  end

  // Reference model: who owns the bus, whether this cycle is the abort cycle,
  // and how many consecutive cycles the owner has been strobing unanswered.
  int mOwner = -1;
  bit mAbort = 1'b0;
  int mStall = 0;
  int mLast  = 1;
  bit mOwnCyc, mOwnStb, mStallNow;

  always @(posedge clk_i) begin
    if (rst_i) begin
      mOwner = -1; mAbort = 1'b0; mStall = 0; mLast = 1;
    end else if (mAbort) begin
      mAbort = 1'b0; mOwner = -1;
    end else if (mOwner >= 0) begin
      mOwnCyc   = (mOwner == 0) ? m0_cyc_i : m1_cyc_i;
      mOwnStb   = (mOwner == 0) ? m0_stb_i : m1_stb_i;
      mStallNow = mOwnStb && !s_ack_i && !s_err_i;
      if (mStallNow && (mStall + 1 == TO)) begin
        mAbort = 1'b1; mStall = 0;
      end else if (!mOwnCyc) begin
        mOwner = -1; mStall = 0;
      end else begin
        mStall = mStallNow ? mStall + 1 : 0;
      end
    end else begin
      if (m0_cyc_i && m1_cyc_i) mOwner = 1 - mLast;
      else if (m0_cyc_i)        mOwner = 0;
      else if (m1_cyc_i)        mOwner = 1;
      if (mOwner >= 0) begin
        mLast = mOwner; mStall = 0;
      end
    end
  end

  function automatic obs_t expected();
    obs_t e = '0;
    e.m0dat = s_dat_i;
    e.m1dat = s_dat_i;
    if (mOwner == 0) e.grant = 2'b01;
    if (mOwner == 1) e.grant = 2'b10;
    if (mAbort) begin
      e.tmo = 1'b1;
      if (mOwner == 0) e.m0err = 1'b1; else e.m1err = 1'b1;
    end else if (mOwner == 0) begin
      e.scyc = m0_cyc_i; e.sstb = m0_stb_i; e.swe = m0_we_i;
      e.sadr = m0_adr_i; e.sdat = m0_dat_i; e.ssel = m0_sel_i;
      e.m0ack = s_ack_i & m0_stb_i; e.m0err = s_err_i & m0_stb_i;
    end else if (mOwner == 1) begin
      e.scyc = m1_cyc_i; e.sstb = m1_stb_i; e.swe = m1_we_i;
      e.sadr = m1_adr_i; e.sdat = m1_dat_i; e.ssel = m1_sel_i;
      e.m1ack = s_ack_i & m1_stb_i; e.m1err = s_err_i & m1_stb_i;
    end
    return e;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idleInputs();
    m0_adr_i = '0; m0_dat_i = '0; m0_sel_i = '0; m0_we_i = 1'b0; m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
    m1_adr_i = '0; m1_dat_i = '0; m1_sel_i = '0; m1_we_i = 1'b0; m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
    s_dat_i = '0; s_ack_i = 1'b0; s_err_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    m0_adr_i = 32'h1234_5678; m0_sel_i = 4'hF; m0_we_i = 1'b1;
    tick(); tick();
    @(negedge clk_i);
    nCompared++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o} !== 10'b0) begin
      nMismatched++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {grant_o, s_cyc_o, s_stb_o, s_we_o, timeout_o, m0_ack_o, m0_err_o, m1_ack_o, m1_err_o});
    end
    nCompared++;
    if ({s_adr_o, s_dat_o, s_sel_o} !== 68'h0) begin
      nMismatched++;
      $display("[TB] FAIL reset_bus: got %h expected 0", {s_adr_o, s_dat_o, s_sel_o});
    end
    tick();
    rst_i = 1'b0;
    idleInputs();
    tick();
  endtask

  task automatic test_single();
    m0_adr_i = 32'h4000_0010; m0_sel_i = 4'hF; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b00) begin
      nMismatched++; $display("[TB] FAIL single_latency: got %b expected 00", grant_o);
    end
    tick();
    @(negedge clk_i);
    nCompared++;
    if ({grant_o, s_cyc_o, s_stb_o, s_adr_o, m0_ack_o} !== {2'b01, 2'b11, 32'h4000_0010, 1'b0}) begin
      nMismatched++;
      $display("[TB] FAIL single_grant: got %h expected %h", {grant_o, s_cyc_o, s_stb_o, s_adr_o, m0_ack_o}, {2'b01, 2'b11, 32'h4000_0010, 1'b0});
    end
    tick();
    s_ack_i = 1'b1; s_dat_i = 32'hDEAD_BEEF;
    @(negedge clk_i);
    nCompared++;
    if ({m0_ack_o, m1_ack_o, m0_err_o, m0_dat_o} !== {3'b100, 32'hDEAD_BEEF}) begin
      nMismatched++;
      $display("[TB] FAIL single_ack: got %h expected %h", {m0_ack_o, m1_ack_o, m0_err_o, m0_dat_o}, {3'b100, 32'hDEAD_BEEF});
    end
    tick();
    idleInputs();
    tick();
    @(negedge clk_i);
    nCompared++;
    if ({grant_o, m0_ack_o} !== 3'b000) begin
      nMismatched++; $display("[TB] FAIL single_release: got %b expected 000", {grant_o, m0_ack_o});
    end
    tick();
  endtask

  task automatic test_tie();
    rst_i = 1'b1; tick(); rst_i = 1'b0;
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b01) begin
      nMismatched++; $display("[TB] FAIL tie_first: got %b expected 01", grant_o);
    end
    tick();
    m0_cyc_i = 1'b0;
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b00) begin
      nMismatched++; $display("[TB] FAIL tie_gap: got %b expected 00", grant_o);
    end
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b10) begin
      nMismatched++; $display("[TB] FAIL tie_handoff: got %b expected 10", grant_o);
    end
    m1_cyc_i = 1'b0;
    tick();
    m0_cyc_i = 1'b1; m1_cyc_i = 1'b1;
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b01) begin
      nMismatched++; $display("[TB] FAIL tie_second: got %b expected 01", grant_o);
    end
    idleInputs();
    tick(); tick();
  endtask

  task automatic test_held();
    int acks = 0;
    int badCycles = 0;
    m1_cyc_i = 1'b1; m1_adr_i = 32'h0000_0100;
    tick();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    for (int i = 0; i < 9; i++) begin
      m1_stb_i = (i % 3 == 0);
      s_ack_i  = m1_stb_i;
      @(negedge clk_i);
      if (m1_ack_o === 1'b1) acks++;
      if (grant_o !== 2'b10 || m0_ack_o !== 1'b0) badCycles++;
      tick();
    end
    nCompared++;
    if (badCycles != 0) begin
      nMismatched++; $display("[TB] FAIL held_grant: got %0d bad cycles expected 0", badCycles);
    end
    nCompared++;
    if (acks != 3) begin
      nMismatched++; $display("[TB] FAIL held_acks: got %0d expected 3", acks);
    end
    m1_stb_i = 1'b0; s_ack_i = 1'b0; m1_cyc_i = 1'b0;
    tick();
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b01) begin
      nMismatched++; $display("[TB] FAIL held_handoff: got %b expected 01", grant_o);
    end
    idleInputs();
    tick(); tick();
  endtask

  task automatic test_timeout();
    int early = 0;
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 32'hBAD0_0000;
    tick();
    for (int k = 0; k < TO; k++) begin
      @(negedge clk_i);
      if ({s_cyc_o, timeout_o, m0_err_o} !== 3'b100) early++;
      tick();
    end
    nCompared++;
    if (early != 0) begin
      nMismatched++; $display("[TB] FAIL timeout_early: got %0d bad cycles expected 0", early);
    end
    @(negedge clk_i);
    nCompared++;
    if ({grant_o, s_cyc_o, s_stb_o, m0_err_o, m1_err_o, timeout_o} !== 7'b01_00101) begin
      nMismatched++;
      $display("[TB] FAIL timeout_abort: got %b expected 0100101", {grant_o, s_cyc_o, s_stb_o, m0_err_o, m1_err_o, timeout_o});
    end
    tick();
    @(negedge clk_i);
    nCompared++;
    if ({grant_o, timeout_o, m0_err_o} !== 4'b0000) begin
      nMismatched++; $display("[TB] FAIL timeout_idle: got %b expected 0000", {grant_o, timeout_o, m0_err_o});
    end
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b01) begin
      nMismatched++; $display("[TB] FAIL timeout_rearb: got %b expected 01", grant_o);
    end
    idleInputs();
    tick(); tick();
  endtask

  task automatic test_ack_threshold();
    m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
    tick();
    repeat (TO - 1) tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    nCompared++;
    if ({m0_ack_o, m0_err_o, timeout_o} !== 3'b100) begin
      nMismatched++; $display("[TB] FAIL thresh_ack: got %b expected 100", {m0_ack_o, m0_err_o, timeout_o});
    end
    tick();
    s_ack_i = 1'b0;
    @(negedge clk_i);
    nCompared++;
    if ({s_cyc_o, m0_err_o, timeout_o} !== 3'b100) begin
      nMismatched++; $display("[TB] FAIL thresh_noabort: got %b expected 100", {s_cyc_o, m0_err_o, timeout_o});
    end
    idleInputs();
    tick(); tick();
  endtask

  task automatic test_reset_mid();
    m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 32'h8000_0004; m1_sel_i = 4'h3; m1_we_i = 1'b1;
    tick(); tick();
    rst_i = 1'b1;
    tick();
    s_ack_i = 1'b1;
    @(negedge clk_i);
    nCompared++;
    if ({grant_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m1_err_o, timeout_o} !== 8'b0) begin
      nMismatched++;
      $display("[TB] FAIL rstmid_ctrl: got %b expected 0", {grant_o, s_cyc_o, s_stb_o, s_we_o, m1_ack_o, m1_err_o, timeout_o});
    end
    nCompared++;
    if ({s_adr_o, s_sel_o} !== 36'h0) begin
      nMismatched++; $display("[TB] FAIL rstmid_bus: got %h expected 0", {s_adr_o, s_sel_o});
    end
    rst_i = 1'b0; s_ack_i = 1'b0; m1_stb_i = 1'b0; m0_cyc_i = 1'b1;
    tick();
    @(negedge clk_i);
    nCompared++;
    if (grant_o !== 2'b01) begin
      nMismatched++; $display("[TB] FAIL rstmid_tie: got %b expected 01", grant_o);
    end
    idleInputs();
    tick(); tick();
  endtask

  task automatic test_random();
    obs_t exp;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) m0_cyc_i = ~m0_cyc_i;
      if ($urandom_range(0, 5) == 0) m1_cyc_i = ~m1_cyc_i;
      m0_stb_i = m0_cyc_i & ($urandom_range(0, 7) != 0);
      m1_stb_i = m1_cyc_i & ($urandom_range(0, 7) != 0);
      m0_adr_i = $urandom; m0_dat_i = $urandom; m0_sel_i = 4'($urandom); m0_we_i = 1'($urandom);
      m1_adr_i = $urandom; m1_dat_i = $urandom; m1_sel_i = 4'($urandom); m1_we_i = 1'($urandom);
      s_dat_i  = $urandom;
      s_ack_i  = ($urandom_range(0, 5) == 0);
      s_err_i  = ($urandom_range(0, 19) == 0);
      rst_i    = ($urandom_range(0, 299) == 0);
      @(negedge clk_i);
      exp = expected();
      nCompared++;
      if (actual !== exp) begin
        nMismatched++;
        $display("[TB] FAIL random_cycle_%0d: got %h expected %h", c, actual, exp);
      end
      tick();
    end
    rst_i = 1'b0;
    idleInputs();
    tick(); tick();
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL bench_timeout: simulation did not finish within time limit");
    $fatal(1, "[TB] time limit expired");
  end

  initial begin
    rst_i = 1'b1;
    idleInputs();
    tick(); tick();
    rst_i = 1'b0;
    tick();
    test_reset();
    test_single();
    test_tie();
    test_held();
    test_timeout();
    test_ack_threshold();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
